// File: rtl/adder_share_ctrl.sv
// Round-robin controller that time-shares one external adder between two requesters.
// Latches the winner's operands, waits SETTLE cycles, then returns the captured sum.
//
// state | meaning
// IDLE  | sampling requests; adder operands hold the previous job
// WAIT  | operands applied, counting SETTLE cycles for the adder to settle
// DONE  | result captured, done pulse to the winner
module adder_share_ctrl #(
  parameter int WIDTH  = 10,
  parameter int SETTLE = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic [WIDTH-1:0] add_in0,
  output logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH:0]   add_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept;
  logic       win;
  logic       capture;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    // On a tie the requester that did not win last time goes first.
    win       = (req0 && req1) ? ~last : req1;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept    = 1'b1;
          last_nxt  = win;
          cnt_nxt   = 8'd0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= 8'd0;
      grant0  <= 1'b0;
      grant1  <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result  <= '0;
      add_in0 <= '0;
      add_in1 <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      grant0 <= accept & ~win;
      grant1 <= accept & win;
      // last already names the current job's owner while in WAIT.
      done0  <= capture & ~last;
      done1  <= capture & last;
      if (accept) begin
        add_in0 <= win ? a1 : a0;
        add_in1 <= win ? b1 : b0;
      end
      if (capture) result <= add_out;
    end
  end

  assign busy = (state != IDLE);

endmodule
